// File: rtl/axis_to_fifo_packer_pkg.sv
// Shared definitions for the packed-FIFO AXIS path (writer and reader sides).
package axis_to_fifo_packer_pkg;

  // Writer FSM state encodings
  typedef enum logic [1:0] {
    WR_TUSER = 2'd0,
    WR_PKT   = 2'd1,
    WR_TERM  = 2'd2
  } wr_state_e;

  // Widest strobe vector supported; users slice the low bits they need
  localparam int unsigned MAX_STRB_W = 128;
  localparam logic [MAX_STRB_W-1:0] ALL_ONES_STRB = '1;

  // Packed FIFO word width: every data byte carries its strobe bit
  function automatic int unsigned packed_width(input int unsigned dw);
    return dw + dw / 8;
  endfunction

endpackage

// File: rtl/axis_to_fifo_packer_byte_pack.sv
// Interleaves each data byte with its strobe bit: word[9i+8:9i] = {strb[i], data[8i+7:8i]}.
module axis_byte_pack
  import axis_to_fifo_packer_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH = 256
) (
  input  logic [C_DATA_WIDTH-1:0]               i_data,
  input  logic [C_DATA_WIDTH/8-1:0]             i_strb,
  output logic [packed_width(C_DATA_WIDTH)-1:0] o_word
);

  localparam int unsigned SW = C_DATA_WIDTH / 8;

  // One 9-bit lane per byte
  for (genvar i = 0; i < SW; i++) begin : g_lane
    assign o_word[9*i +: 9] = {i_strb[i], i_data[8*i +: 8]};
  end

endmodule

// File: rtl/axis_to_fifo_packer.sv
// Writes AXIS packets into a FIFO as packed words: a TUSER word, the data beats,
// and an all-zero terminator when the last beat carries a full strobe.
module axis_to_fifo_packer
  import axis_to_fifo_packer_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned C_CNT_WIDTH          = 32
) (
  input  logic                                         axi_aclk,
  input  logic                                         axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]               s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]             s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]              s_axis_tuser,
  input  logic                                         s_axis_tvalid,
  output logic                                         s_axis_tready,
  input  logic                                         s_axis_tlast,
  output logic [packed_width(C_S_AXIS_DATA_WIDTH)-1:0] fifo_din,
  output logic                                         fifo_wr_en,
  input  logic                                         fifo_full,
  input  logic                                         sw_rst,
  output logic [C_CNT_WIDTH-1:0]                       pkt_count,
  output logic [C_CNT_WIDTH-1:0]                       err_count
);

  localparam int unsigned DW = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;

  wr_state_e              r_state;
  wr_state_e              w_next_state;
  logic [C_CNT_WIDTH-1:0] r_pkt_count;
  logic [C_CNT_WIDTH-1:0] r_err_count;
  logic [DW-1:0]          w_pack_data;
  logic [SW-1:0]          w_pack_strb;
  logic                   w_strb_full;
  logic                   w_pkt_inc;
  logic                   w_err_inc;

  assign w_strb_full = (s_axis_tstrb == ALL_ONES_STRB[SW-1:0]);
  assign pkt_count   = r_pkt_count;
  assign err_count   = r_err_count;

  // Next state, handshake, write strobe and the word to pack, all from state and inputs
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    w_next_state  = r_state;
    fifo_wr_en    = 1'b0;
    s_axis_tready = 1'b0;
    w_pack_data   = s_axis_tdata;
    w_pack_strb   = s_axis_tstrb;
    w_pkt_inc     = 1'b0;
    w_err_inc     = 1'b0;

    case (r_state)
      WR_TUSER: begin
        // Header word is written from the first beat's sideband; the beat itself waits
        w_pack_data = DW'(s_axis_tuser);
        w_pack_strb = ALL_ONES_STRB[SW-1:0];
        if (s_axis_tvalid && !fifo_full) begin
          fifo_wr_en   = 1'b1;
          w_next_state = WR_PKT;
        end
      end
      WR_PKT: begin
        s_axis_tready = !fifo_full;
        if (s_axis_tvalid && !fifo_full) begin
          fifo_wr_en = 1'b1;
          if (s_axis_tlast) begin
            if (w_strb_full) begin
              // Reader ends a packet on a non-full strobe, so one more word is owed
              w_next_state = WR_TERM;
            end else begin
              w_pkt_inc    = 1'b1;
              w_next_state = WR_TUSER;
            end
          end else if (!w_strb_full) begin
            // A partial strobe mid-packet would end the packet early at the reader
            w_pack_strb = ALL_ONES_STRB[SW-1:0];
            w_err_inc   = 1'b1;
          end
        end
      end
      WR_TERM: begin
        w_pack_data = '0;
        w_pack_strb = '0;
        if (!fifo_full) begin
          fifo_wr_en   = 1'b1;
          w_pkt_inc    = 1'b1;
          w_next_state = WR_TUSER;
        end
      end
      default: w_next_state = WR_TUSER;
    endcase

    // Either reset silences the interface immediately, including a same-cycle handshake
    if (axi_areset || sw_rst) begin
      fifo_wr_en    = 1'b0;
      s_axis_tready = 1'b0;
      w_pkt_inc     = 1'b0;
      w_err_inc     = 1'b0;
      w_next_state  = WR_TUSER;
    end
  end

  // State register and wrapping packet/error counters
  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (axi_areset) begin
      r_state     <= WR_TUSER;
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else if (sw_rst) begin
      r_state     <= WR_TUSER;
      r_pkt_count <= '0;
      r_err_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_pkt_inc) r_pkt_count <= r_pkt_count + C_CNT_WIDTH'(1);
      if (w_err_inc) r_err_count <= r_err_count + C_CNT_WIDTH'(1);
    end
  end

  axis_byte_pack #(
    .C_DATA_WIDTH(DW)
  ) u_byte_pack (
    .i_data(w_pack_data),
    .i_strb(w_pack_strb),
    .o_word(fifo_din)
  );

endmodule
